// File: rtl/retire_trace_emitter_if.sv
// rtl/retire_trace_emitter_if.sv - commit-sample bus and trace record stream for the retire trace emitter
interface retire_trace_emitter_if;
  logic        en;
  logic [15:0] pc;
  logic        regwrite;
  logic [3:0]  wreg;
  logic [15:0] wdata;
  logic        memread;
  logic        memwrite;
  logic [15:0] memaddr;
  logic [15:0] memdata;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [70:0] out_rec;

  modport master (
    output en, pc, regwrite, wreg, wdata, memread, memwrite, memaddr, memdata, halt, out_ready,
    input  out_valid, out_rec
  );

  modport slave (
    input  en, pc, regwrite, wreg, wdata, memread, memwrite, memaddr, memdata, halt, out_ready,
    output out_valid, out_rec
  );
endinterface

// File: rtl/retire_trace_emitter.sv
// rtl/retire_trace_emitter.sv - classifies retire cycles into trace records, buffers and streams them
module retire_trace_emitter #(
  parameter int DEPTH    = 8,
  parameter int EMIT_NOP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  retire_trace_emitter_if.slave  bus,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT_OUT, S_FIN} state_t;

  localparam logic [2:0] T_NOP   = 3'd0;
  localparam logic [2:0] T_REG   = 3'd1;
  localparam logic [2:0] T_LOAD  = 3'd2;
  localparam logic [2:0] T_STORE = 3'd3;
  localparam logic [2:0] T_HALT  = 3'd4;

  state_t      state;
  logic [70:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [15:0] cyc_cnt, inst_cnt;
  logic [70:0] halt_rec;

  logic        cap, empty, full, pop, want_push, push, drop;
  logic [2:0]  rtype;
  logic [3:0]  rreg;
  logic [15:0] ra, rb;
  logic [70:0] rec;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign cap   = bus.en && (state == S_RUN);

  always_comb begin
    rtype = T_NOP;
    rreg  = 4'd0;
    ra    = 16'd0;
    rb    = 16'd0;
    if (bus.regwrite && bus.memread) begin
      rtype = T_LOAD;
      rreg  = bus.wreg;
      ra    = bus.wdata;
      rb    = bus.memaddr;
    end else if (bus.regwrite) begin
      rtype = T_REG;
      rreg  = bus.wreg;
      ra    = bus.wdata;
    end else if (bus.halt) begin
      rtype = T_HALT;
    end else if (bus.memwrite) begin
      rtype = T_STORE;
      ra    = bus.memaddr;
      rb    = bus.memdata;
    end
  end

  assign rec = {rtype, inst_cnt, bus.pc, rreg, ra, rb};

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_rec   = 71'd0;
    case (state)
      S_RUN, S_DRAIN: begin
        bus.out_valid = !empty;
        if (!empty) bus.out_rec = mem[rptr[AW-1:0]];
      end
      S_HALT_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_rec   = halt_rec;
      end
      default: ;
    endcase
  end

  // A full FIFO still takes the new record when the head leaves on the same edge.
  assign pop       = bus.out_valid && bus.out_ready && (state == S_RUN || state == S_DRAIN);
  assign want_push = cap && (rtype != T_HALT) && ((EMIT_NOP != 0) || (rtype != T_NOP));
  assign push      = want_push && (!full || pop);
  assign drop      = want_push && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      wptr     <= '0;
      rptr     <= '0;
      cyc_cnt  <= 16'd0;
      inst_cnt <= 16'd0;
      halt_rec <= 71'd0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
      done     <= 1'b0;
    end else begin
      if (cap) begin
        cyc_cnt  <= cyc_cnt + 16'd1;
        inst_cnt <= inst_cnt + 16'd1;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      case (state)
        S_RUN: begin
          // Halt bypasses the FIFO so it can never be lost to overflow.
          if (cap && rtype == T_HALT) begin
            halt_rec <= {T_HALT, inst_cnt, bus.pc, 4'd0, cyc_cnt + 16'd1, inst_cnt + 16'd1};
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (empty) state <= S_HALT_OUT;
        end
        S_HALT_OUT: begin
          if (bus.out_ready) begin
            state <= S_FIN;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_retire_trace_emitter.sv
// tb/tb_retire_trace_emitter.sv - scoreboard bench for retire_trace_emitter
module tb_retire_trace_emitter;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_b = 1'b0;
  logic rdy_b = 1'b0;

  retire_trace_emitter_if ifa ();
  retire_trace_emitter_if ifb ();

  logic        ovf_a, ovf_b, done_a, done_b;
  logic [15:0] drops_a, drops_b;

  retire_trace_emitter #(.DEPTH(DEPTH), .EMIT_NOP(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .overflow(ovf_a), .drop_cnt(drops_a), .done(done_a)
  );

  retire_trace_emitter #(.DEPTH(DEPTH), .EMIT_NOP(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .overflow(ovf_b), .drop_cnt(drops_b), .done(done_b)
  );

  assign ifb.en        = en_b;
  assign ifb.out_ready = rdy_b;
  assign ifb.pc        = ifa.pc;
  assign ifb.regwrite  = ifa.regwrite;
  assign ifb.wreg      = ifa.wreg;
  assign ifb.wdata     = ifa.wdata;
  assign ifb.memread   = ifa.memread;
  assign ifb.memwrite  = ifa.memwrite;
  assign ifb.memaddr   = ifa.memaddr;
  assign ifb.memdata   = ifa.memdata;
  assign ifb.halt      = ifa.halt;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  logic [70:0] exp_q[$];
  int          m_occ;
  int          m_drops;
  logic [15:0] m_inst, m_cyc;
  bit          m_halted;

  bit          stall_seen = 1'b0;
  logic [70:0] stall_rec;

  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && ifa.out_valid) chk("hold", ifa.out_rec, stall_rec);
      if (ifa.out_valid && ifa.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rec", ifa.out_rec, 71'd0 - 71'd1);
        else chk("rec", ifa.out_rec, exp_q.pop_front());
      end
      stall_seen = ifa.out_valid && !ifa.out_ready;
      stall_rec  = ifa.out_rec;
    end
  end

  task automatic step(input logic e, input logic rw, input logic [3:0] wr, input logic [15:0] wd,
                      input logic mr, input logic mw, input logic [15:0] ma, input logic [15:0] md,
                      input logic hl, input logic [15:0] p, input logic rdy);
    logic [2:0]  t;
    logic [3:0]  r;
    logic [15:0] a, b;
    bit          pop, push;
    ifa.en = e; ifa.regwrite = rw; ifa.wreg = wr; ifa.wdata = wd; ifa.memread = mr;
    ifa.memwrite = mw; ifa.memaddr = ma; ifa.memdata = md; ifa.halt = hl; ifa.pc = p;
    ifa.out_ready = rdy;
    pop  = (m_occ > 0) && rdy;
    push = 1'b0;
    if (e && !m_halted) begin
      m_cyc++;
      t = 3'd0; r = 4'd0; a = 16'd0; b = 16'd0;
      if (rw && mr)  begin t = 3'd2; r = wr; a = wd; b = ma; end
      else if (rw)   begin t = 3'd1; r = wr; a = wd; end
      else if (hl)   t = 3'd4;
      else if (mw)   begin t = 3'd3; a = ma; b = md; end
      if (t == 3'd4) begin
        exp_q.push_back({3'd4, m_inst, p, 4'd0, m_cyc, m_inst + 16'd1});
        m_halted = 1'b1;
      end else if (m_occ < DEPTH || pop) begin
        exp_q.push_back({t, m_inst, p, r, a, b});
        push = 1'b1;
      end else begin
        m_drops++;
      end
      m_inst++;
    end
    m_occ = m_occ + int'(push) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, rdy);
  endtask

  task automatic reg_op(input logic [3:0] wr, input logic [15:0] wd, input logic [15:0] p, input logic rdy);
    step(1'b1, 1'b1, wr, wd, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, p, rdy);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_occ = 0; m_drops = 0; m_inst = 16'd0; m_cyc = 16'd0; m_halted = 1'b0;
    chk("rst_valid", ifa.out_valid, 1'b0);
    chk("rst_rec", ifa.out_rec, 71'd0);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_drops", drops_a, 16'd0);
    chk("rst_done", done_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifa.out_ready = 1'b0;
    idle(1'b0);
    do_reset();

    // 1: single REG record, latency one
    reg_op(4'd3, 16'h00AB, 16'h0002, 1'b1);
    chk("lat_valid", ifa.out_valid, 1'b1);
    chk("lat_rec", ifa.out_rec, {3'd1, 16'd0, 16'h0002, 4'd3, 16'h00AB, 16'd0});
    repeat (3) idle(1'b1);
    chk("t1_sb_empty", 71'(exp_q.size()), 71'd0);

    // 2: STORE then LOAD
    do_reset();
    step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0010, 1'b1);
    step(1'b1, 1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0012, 1'b1);
    repeat (4) idle(1'b1);
    chk("t2_sb_empty", 71'(exp_q.size()), 71'd0);

    // 3: overflow with stalled sink
    do_reset();
    for (int i = 0; i < 10; i++) reg_op(4'(i), 16'(16'h0100 + i), 16'(2 * i), 1'b0);
    chk("t3_ovf", ovf_a, 1'b1);
    chk("t3_drops", drops_a, 71'(m_drops));
    chk("t3_drops_two", drops_a, 16'd2);
    repeat (10) idle(1'b1);
    chk("t3_sb_empty", 71'(exp_q.size()), 71'd0);

    // 4: full FIFO with simultaneous pop accepts the push
    for (int i = 0; i < DEPTH; i++) reg_op(4'd7, 16'(16'h0200 + i), 16'h0030, 1'b0);
    reg_op(4'd9, 16'h0BEE, 16'h0034, 1'b1);
    chk("t4_drops", drops_a, 16'd2);
    repeat (12) idle(1'b1);
    chk("t4_sb_empty", 71'(exp_q.size()), 71'd0);

    // 5: halt with stalled sink, summary record, done, later inputs ignored
    do_reset();
    for (int i = 0; i < 3; i++) reg_op(4'd1, 16'(16'h0300 + i), 16'(16'h0040 + 2 * i), 1'b0);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 16'h0046, 1'b0);
    reg_op(4'd2, 16'hDEAD, 16'h0048, 1'b0);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h004A, 1'b0);
    for (int i = 0; i < 20 && !done_a; i++) idle(1'b1);
    chk("t5_done", done_a, 1'b1);
    chk("t5_sb_empty", 71'(exp_q.size()), 71'd0);
    for (int i = 0; i < DEPTH + 2; i++) reg_op(4'd4, 16'h5555, 16'h0050, 1'b0);
    chk("t5_post_valid", ifa.out_valid, 1'b0);
    chk("t5_post_done", done_a, 1'b1);
    chk("t5_post_drops", drops_a, 16'd0);

    // 6: EMIT_NOP=0 instance, then reset during DRAIN
    do_reset();
    rdy_b = 1'b0;
    en_b  = 1'b1;
    idle(1'b0);
    reg_op(4'd6, 16'h0077, 16'h0060, 1'b0);
    ifa.en = 1'b0;
    en_b = 1'b0;
    chk("t6_valid", ifb.out_valid, 1'b1);
    chk("t6_rec", ifb.out_rec, {3'd1, 16'd1, 16'h0060, 4'd6, 16'h0077, 16'd0});
    exp_q.delete();
    m_occ = 0;
    en_b = 1'b1;
    idle(1'b0);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 16'h0064, 1'b0);
    en_b = 1'b0;
    chk("t6_drain_valid", ifb.out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", ifb.out_valid, 1'b0);
    chk("t6_rst_done", done_b, 1'b0);
    chk("t6_rst_rec", ifb.out_rec, 71'd0);
    rst = 1'b0;
    repeat (2) idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
